instruction_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS32 pipeline, directly upstream of the ID-stage control decoder. It owns the PC register and selects the next PC from the decoder's `PCSrcSel` and the ID-stage targets. It drives a req/ack instruction-memory port and holds the IF/ID pipeline register (instruction, PC+4, valid, branch-delay-slot flag). It honours stall and flush from the hazard unit.

---
 rtl/instruction_fetch_pkg.sv | 26 ++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the MIPS32 instruction-fetch stage: widths, next-PC
// select encodings, the bubble word and the fetch FSM states.
package instruction_fetch_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int ADDR_WIDTH  = 32;

   localparam logic [1:0] PCSRC_PC4 = 2'b00;
   localparam logic [1:0] PCSRC_JR  = 2'b01;
   localparam logic [1:0] PCSRC_BR  = 2'b10;
   localparam logic [1:0] PCSRC_J   = 2'b11;

   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = '0;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2
   } ifState_t;

   // Targets are silently word-aligned; misaligned targets raise no exception.
   function automatic logic [ADDR_WIDTH-1:0] alignWord(input logic [ADDR_WIDTH-1:0] a);
      return a & ~ADDR_WIDTH'(3);
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues req/ack fetches, and holds the IF/ID register
// with delay-slot redirect and BDS tracking, honouring stall and flush.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   IF_Stall,
   input  logic                   IF_Flush,
   input  logic [1:0]             PCSrcSel,
   input  logic                   NextIsDelay,
   input  logic [ADDR_WIDTH-1:0]  JumpRegAddr,
   input  logic [ADDR_WIDTH-1:0]  BranchTarget,
   input  logic [ADDR_WIDTH-1:0]  JumpTarget,
   output logic                   IMem_Req,
   output logic [ADDR_WIDTH-1:0]  IMem_Addr,
   input  logic                   IMem_Ack,
   input  logic [INSTR_WIDTH-1:0] IMem_RData,
   output logic [INSTR_WIDTH-1:0] ID_Instruction,
   output logic [ADDR_WIDTH-1:0]  ID_PCAdd4,
   output logic                   ID_Valid,
   output logic                   ID_IsBDS
);

   ifState_t                state, nextState;
   logic [ADDR_WIDTH-1:0]   pc, pcPlus4, nextPc, selTarget, redirTarget;
   logic                    redirPend, bdsPend;
   logic [INSTR_WIDTH-1:0]  holdInstr;
   logic [ADDR_WIDTH-1:0]   holdPcAdd4;
   logic                    fetchAck, redirCap, bdsNow;
   logic                    loadFetch, loadHold, realLoad, loadBubble, holdCapture;

   assign IMem_Addr = alignWord(pc);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IF_IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      IMem_Req  = 1'b0;
      case (state)
         IF_IDLE:  nextState = IF_FETCH;
         IF_FETCH: begin
            IMem_Req = 1'b1;
            if (IMem_Ack && IF_Stall && !IF_Flush) nextState = IF_HOLD;
         end
         IF_HOLD:  if (IF_Flush || !IF_Stall) nextState = IF_FETCH;
         default:  nextState = IF_IDLE;
      endcase
   end

   // The instruction in ID is the branch; the fetch in flight is its delay
   // slot, so the target steers the PC after that fetch completes.
   always_comb begin
      fetchAck = (state == IF_FETCH) && IMem_Ack;
      redirCap = ID_Valid && !IF_Stall && (PCSrcSel != PCSRC_PC4);
      case (PCSrcSel)
         PCSRC_JR: selTarget = alignWord(JumpRegAddr);
         PCSRC_BR: selTarget = alignWord(BranchTarget);
         PCSRC_J:  selTarget = alignWord(JumpTarget);
         default:  selTarget = alignWord(pc);
      endcase
      pcPlus4 = pc + ADDR_WIDTH'(4);
      if (redirCap)       nextPc = selTarget;
      else if (redirPend) nextPc = redirTarget;
      else                nextPc = pcPlus4;
      bdsNow      = bdsPend || (redirCap && NextIsDelay);
      loadFetch   = fetchAck && !IF_Stall && !IF_Flush;
      loadHold    = (state == IF_HOLD) && !IF_Stall && !IF_Flush;
      realLoad    = loadFetch || loadHold;
      loadBubble  = IF_Flush || (!IF_Stall && !realLoad);
      holdCapture = fetchAck && IF_Stall && !IF_Flush;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= RESET_VECTOR;
         redirPend   <= 1'b0;
         redirTarget <= '0;
         bdsPend     <= 1'b0;
      end else begin
         if (fetchAck) begin
            pc        <= nextPc;
            redirPend <= 1'b0;
         end else if (redirCap) begin
            redirPend   <= 1'b1;
            redirTarget <= selTarget;
         end
         if (realLoad)                     bdsPend <= 1'b0;
         else if (redirCap && NextIsDelay) bdsPend <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         holdInstr  <= INSTR_NOP;
         holdPcAdd4 <= '0;
      end else if (holdCapture) begin
         holdInstr  <= IMem_RData;
         holdPcAdd4 <= pcPlus4;
      end
   end

   // IF/ID register: flush and wait cycles load a bubble, stall holds it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ID_Instruction <= INSTR_NOP;
         ID_PCAdd4      <= '0;
         ID_Valid       <= 1'b0;
         ID_IsBDS       <= 1'b0;
      end else if (realLoad) begin
         ID_Instruction <= loadFetch ? IMem_RData : holdInstr;
         ID_PCAdd4      <= loadFetch ? pcPlus4 : holdPcAdd4;
         ID_Valid       <= 1'b1;
         ID_IsBDS       <= bdsNow;
      end else if (loadBubble) begin
         ID_Instruction <= INSTR_NOP;
         ID_PCAdd4      <= '0;
         ID_Valid       <= 1'b0;
         ID_IsBDS       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: word=addr memory, expected IF/ID
// contents queued per cycle and compared one edge later.
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        IF_Stall, IF_Flush, NextIsDelay;
   logic [1:0]  PCSrcSel;
   logic [31:0] JumpRegAddr, BranchTarget, JumpTarget;
   logic        IMem_Req, IMem_Ack;
   logic [31:0] IMem_Addr, IMem_RData;
   logic [31:0] ID_Instruction, ID_PCAdd4;
   logic        ID_Valid, ID_IsBDS;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcAdd4;
      logic        valid;
      logic        bds;
   } idExp_t;

   idExp_t sb[$];

   always #5 clock = ~clock;

   // Memory model: the fetched word equals its address.
   assign IMem_RData = IMem_Addr;

   instruction_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush),
      .PCSrcSel(PCSrcSel), .NextIsDelay(NextIsDelay), .JumpRegAddr(JumpRegAddr),
      .BranchTarget(BranchTarget), .JumpTarget(JumpTarget),
      .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack),
      .IMem_RData(IMem_RData), .ID_Instruction(ID_Instruction), .ID_PCAdd4(ID_PCAdd4),
      .ID_Valid(ID_Valid), .ID_IsBDS(ID_IsBDS)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pa4,
                       input logic valid, input logic bds);
      idExp_t e;
      e.instr = instr; e.pcAdd4 = pa4; e.valid = valid; e.bds = bds;
      sb.push_back(e);
   endtask

   // Check the request side now, clock once, then compare IF/ID to the queue.
   task automatic tick(input logic expReq, input logic [31:0] expAddr);
      idExp_t e;
      chk("imem_req", {31'b0, IMem_Req}, {31'b0, expReq});
      chk("imem_addr", IMem_Addr, expAddr);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed=0 entries expected=1");
      end else begin
         e = sb.pop_front();
         chk("id_instr",  ID_Instruction, e.instr);
         chk("id_pcadd4", ID_PCAdd4, e.pcAdd4);
         chk("id_valid",  {31'b0, ID_Valid}, {31'b0, e.valid});
         chk("id_bds",    {31'b0, ID_IsBDS}, {31'b0, e.bds});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; IF_Stall = 0; IF_Flush = 0; PCSrcSel = 2'b00; NextIsDelay = 0;
      JumpRegAddr = 0; BranchTarget = 0; JumpTarget = 0; IMem_Ack = 0;
      @(posedge clock); #1;
      chk("rst_req", {31'b0, IMem_Req}, 32'd0);
      chk("rst_addr", IMem_Addr, 32'h0);
      chk("rst_valid", {31'b0, ID_Valid}, 32'd0);
      chk("rst_instr", ID_Instruction, 32'h0);
      reset = 1'b0;

      // IDLE cycle, then zero-wait fetches 0, 4
      push(0, 0, 0, 0);           tick(1'b0, 32'h0);
      IMem_Ack = 1;
      push(32'h0, 32'h4, 1, 0);   tick(1'b1, 32'h0);
      push(32'h4, 32'h8, 1, 0);   tick(1'b1, 32'h4);

      // Two wait states at 0x8: address held, two bubbles
      IMem_Ack = 0;
      push(0, 0, 0, 0);           tick(1'b1, 32'h8);
      push(0, 0, 0, 0);           tick(1'b1, 32'h8);
      IMem_Ack = 1;
      push(32'h8, 32'hC, 1, 0);   tick(1'b1, 32'h8);
      push(32'hC, 32'h10, 1, 0);  tick(1'b1, 32'hC);
      push(32'h10, 32'h14, 1, 0); tick(1'b1, 32'h10);

      // Branch at 0x10 in ID, delay slot 0x14 acked in the same cycle
      PCSrcSel = 2'b10; BranchTarget = 32'h40; NextIsDelay = 1;
      push(32'h14, 32'h18, 1, 1); tick(1'b1, 32'h14);
      PCSrcSel = 2'b00; NextIsDelay = 0;
      push(32'h40, 32'h44, 1, 0); tick(1'b1, 32'h40);
      push(32'h44, 32'h48, 1, 0); tick(1'b1, 32'h44);

      // jr at 0x44 while 0x48 waits: target latched, applied after the ack
      PCSrcSel = 2'b01; JumpRegAddr = 32'h103; NextIsDelay = 1; IMem_Ack = 0;
      push(0, 0, 0, 0);           tick(1'b1, 32'h48);
      PCSrcSel = 2'b00; NextIsDelay = 0; IMem_Ack = 1;
      push(32'h48, 32'h4C, 1, 1); tick(1'b1, 32'h48);
      push(32'h100, 32'h104, 1, 0); tick(1'b1, 32'h100);

      // Stall 3 cycles while 0x104 is acked
      IF_Stall = 1;
      push(32'h100, 32'h104, 1, 0); tick(1'b1, 32'h104);
      IMem_Ack = 0;
      push(32'h100, 32'h104, 1, 0); tick(1'b0, 32'h108);
      push(32'h100, 32'h104, 1, 0); tick(1'b0, 32'h108);
      IF_Stall = 0;
      push(32'h104, 32'h108, 1, 0); tick(1'b0, 32'h108);
      IMem_Ack = 1;
      push(32'h108, 32'h10C, 1, 0); tick(1'b1, 32'h108);

      // Flush discards the acked word but the PC still advances
      IF_Flush = 1;
      push(0, 0, 0, 0);           tick(1'b1, 32'h10C);
      IF_Flush = 0; IMem_Ack = 0;
      push(0, 0, 0, 0);           tick(1'b1, 32'h110);
      IMem_Ack = 1;
      push(32'h110, 32'h114, 1, 0); tick(1'b1, 32'h110);

      // Asynchronous reset mid-request with no edge in between
      IMem_Ack = 0;
      #2 reset = 1'b1;
      #1;
      chk("async_req", {31'b0, IMem_Req}, 32'd0);
      chk("async_addr", IMem_Addr, 32'h0);
      chk("async_instr", ID_Instruction, 32'h0);
      chk("async_pcadd4", ID_PCAdd4, 32'h0);
      chk("async_valid", {31'b0, ID_Valid}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      push(0, 0, 0, 0);           tick(1'b0, 32'h0);
      IMem_Ack = 1;
      push(32'h0, 32'h4, 1, 0);   tick(1'b1, 32'h0);
      push(32'h4, 32'h8, 1, 0);   tick(1'b1, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
